if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 68 ++++++
 tb/tb_if_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a 2-entry bundle FIFO and redirect handling.
// A redirect that races an unacked request parks in DISCARD until that request retires.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  output logic        p1_valid,
  output logic [15:0] p1_aluInstr,
  output logic [15:0] p1_memInstr,
  output logic [31:0] p1_pc
);
  typedef enum logic {FETCH, DISCARD} stateT;
  stateT       state;
  logic [31:0] fetchPc, discAddr;
  logic        pend, head, tail, push, pop;
  logic [1:0]  count;
  logic [15:0] aluQ [2];
  logic [15:0] memQ [2];
  logic [31:0] pcQ  [2];
  always_comb begin
    p1_valid    = count != 2'd0;
    pop         = p1_valid & id_ready & ~redirect_en;
    imem_req    = reset & (state == DISCARD | pend | ~count[1] | pop);
    imem_addr   = state == DISCARD ? discAddr : fetchPc;
    push        = state == FETCH & imem_req & imem_ack & ~redirect_en;
    tail        = head ^ count[0];
    p1_aluInstr = p1_valid ? aluQ[head] : 16'h0000;
    p1_memInstr = p1_valid ? memQ[head] : 16'h0000;
    p1_pc       = p1_valid ? pcQ[head] : 32'h0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      fetchPc  <= 32'h0;
      discAddr <= 32'h0;
      pend     <= 1'b0;
      head     <= 1'b0;
      count    <= 2'd0;
    end else begin
      pend  <= imem_req & ~imem_ack;
      state <= (imem_req & ~imem_ack & (redirect_en | state == DISCARD)) ? DISCARD : FETCH;
      if (state == FETCH) discAddr <= fetchPc;
      if (redirect_en) fetchPc <= redirect_target & ~32'd3;
      else if (state == FETCH & imem_req & imem_ack) fetchPc <= fetchPc + 32'd4;
      if (redirect_en) begin
        head  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (pop) head <= ~head;
        count <= count + 2'(push) - 2'(pop);
      end
    end
  end
  // Payload slots need no reset: they are only observed while count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      aluQ[tail] <= imem_rdata[15:0];
      memQ[tail] <= imem_rdata[31:16];
      pcQ[tail]  <= imem_addr;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed fetch scenarios checked against a queue-based model every cycle.
module tb_if_stage;
  logic        clk = 1'b0, reset = 1'b0;
  logic        imem_req, imem_ack = 1'b0, id_ready = 1'b0, redirect_en = 1'b0, p1_valid;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_target = '0, p1_pc;
  logic [15:0] p1_aluInstr, p1_memInstr;
  int          nChecks = 0, nPass = 0;
  logic [63:0] q[$];
  logic [31:0] mPc = '0, mDisc = '0;
  bit          disc = 0, pend = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_ready(id_ready),
    .redirect_en(redirect_en), .redirect_target(redirect_target),
    .p1_valid(p1_valid), .p1_aluInstr(p1_aluInstr), .p1_memInstr(p1_memInstr), .p1_pc(p1_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic bit expReq();
    return reset && (disc || pend || q.size() < 2 || (q.size() == 2 && id_ready && !redirect_en));
  endfunction

  task automatic modelReset();
    q.delete();
    mPc = '0; mDisc = '0; disc = 0; pend = 0;
  endtask

  task automatic modelStep();
    bit req, newDisc;
    logic [31:0] addr;
    req = expReq();
    addr = disc ? mDisc : mPc;
    newDisc = req && !imem_ack && (redirect_en || disc);
    if (redirect_en) q.delete();
    else begin
      if (q.size() > 0 && !disc && id_ready) void'(q.pop_front());
      if (!disc && req && imem_ack) q.push_back({addr, imem_rdata});
    end
    if (newDisc && !disc) mDisc = mPc;
    if (redirect_en) mPc = {redirect_target[31:2], 2'b00};
    else if (!disc && req && imem_ack) mPc = mPc + 32'd4;
    pend = req && !imem_ack;
    disc = newDisc;
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) modelReset();
    chk("m_req", imem_req, expReq());
    chk("m_addr", imem_addr, disc ? mDisc : mPc);
    chk("m_valid", p1_valid, q.size() != 0);
    chk("m_alu", p1_aluInstr, q.size() != 0 ? q[0][15:0] : 32'h0);
    chk("m_mem", p1_memInstr, q.size() != 0 ? q[0][31:16] : 32'h0);
    chk("m_pc", p1_pc, q.size() != 0 ? q[0][63:32] : 32'h0);
    @(posedge clk);
    if (!reset) modelReset();
    else modelStep();
  end

  task automatic set(input bit ack, input logic [31:0] rd, input bit rdy, input bit redir, input logic [31:0] tgt);
    imem_ack = ack; imem_rdata = rd; id_ready = rdy; redirect_en = redir; redirect_target = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    #1 reset = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_addr", imem_addr, 0);
    chk("async_valid", p1_valid, 0);
    chk("async_pc", p1_pc, 0);
    set(0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", p1_valid, 0);
    chk("rst_alu", p1_aluInstr, 0);
    chk("rst_pc", p1_pc, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set(1, 32'h1111_2222, 1, 0, 0);
      chk("stream_req", imem_req, 1);
      chk("stream_addr", imem_addr, 4 * i);
      if (i == 0) chk("stream_lat", p1_valid, 0);
      else begin
        chk("stream_pc", p1_pc, 4 * (i - 1));
        chk("stream_alu", p1_aluInstr, 32'h2222);
        chk("stream_mem", p1_memInstr, 32'h1111);
      end
      tick();
    end
    set(0, 0, 1, 0, 0);
    chk("stream_last", p1_pc, 32'h10);
    tick();
    doReset();
    set(1, 32'hA0A0_B0B0, 0, 0, 0); chk("buf_addr0", imem_addr, 0); tick();
    set(1, 32'hA1A1_B1B1, 0, 0, 0); chk("buf_addr4", imem_addr, 4); chk("buf_pc0", p1_pc, 0); tick();
    set(0, 0, 0, 0, 0); chk("buf_full_req", imem_req, 0); chk("buf_full_valid", p1_valid, 1); tick();
    set(1, 32'hA2A2_B2B2, 1, 0, 0); chk("buf_resume_req", imem_req, 1); chk("buf_addr8", imem_addr, 8);
    chk("buf_head0", p1_pc, 0); chk("buf_alu0", p1_aluInstr, 32'hB0B0); tick();
    set(1, 32'hA3A3_B3B3, 1, 0, 0); chk("buf_addrC", imem_addr, 12); chk("buf_head4", p1_pc, 4); tick();
    set(0, 0, 1, 0, 0); chk("buf_head8", p1_pc, 8); chk("buf_mem8", p1_memInstr, 32'hA2A2); tick();
    doReset();
    set(1, 32'h0, 1, 0, 0); tick();
    set(1, 32'h0, 1, 0, 0); chk("dis_addr4", imem_addr, 4); tick();
    set(0, 0, 1, 0, 0); chk("dis_addr8", imem_addr, 8); tick();
    set(0, 0, 1, 1, 32'h103); chk("dis_redir_addr", imem_addr, 8); tick();
    set(0, 0, 1, 0, 0); chk("dis_hold_req", imem_req, 1); chk("dis_hold_addr", imem_addr, 8);
    chk("dis_valid", p1_valid, 0); tick();
    set(0, 0, 1, 0, 0); tick();
    set(1, 32'hDEAD_BEEF, 1, 0, 0); chk("dis_ack_addr", imem_addr, 8); tick();
    set(1, 32'h3333_4444, 1, 0, 0); chk("dis_new_addr", imem_addr, 32'h100); chk("dis_dropped", p1_valid, 0); tick();
    set(0, 0, 1, 0, 0); chk("dis_new_pc", p1_pc, 32'h100); chk("dis_new_alu", p1_aluInstr, 32'h4444); tick();
    set(0, 0, 1, 1, 32'h300); chk("dis2_addr", imem_addr, 32'h104); tick();
    set(0, 0, 1, 1, 32'h405); chk("dis2_hold", imem_addr, 32'h104); tick();
    set(1, 32'h5, 1, 0, 0); tick();
    set(1, 32'h6, 1, 0, 0); chk("dis2_target", imem_addr, 32'h404); tick();
    set(0, 0, 1, 0, 0); chk("dis2_pc", p1_pc, 32'h404); tick();
    doReset();
    set(1, 32'h1, 1, 0, 0); tick();
    set(1, 32'h2, 1, 0, 0); tick();
    set(1, 32'h3, 1, 0, 0); tick();
    set(1, 32'h4, 1, 1, 32'h40); chk("fl_addrC", imem_addr, 32'hC); chk("fl_pc8", p1_pc, 8); tick();
    set(1, 32'h5, 1, 0, 0); chk("fl_empty", p1_valid, 0); chk("fl_addr40", imem_addr, 32'h40); tick();
    set(0, 0, 1, 0, 0); chk("fl_pc40", p1_pc, 32'h40); tick();
    set(1, 32'h6, 1, 1, 32'hFFFF_FFFF); chk("wr_addr44", imem_addr, 32'h44); tick();
    set(1, 32'h7, 1, 0, 0); chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC); tick();
    set(1, 32'h8, 1, 0, 0); chk("wr_addr0", imem_addr, 0); chk("wr_pc_top", p1_pc, 32'hFFFF_FFFC); tick();
    set(0, 0, 0, 0, 0); chk("ar_pre_addr", imem_addr, 4); chk("ar_pre_valid", p1_valid, 1);
    doReset();
    set(0, 0, 1, 0, 0); chk("ar_post_req", imem_req, 1); chk("ar_post_addr", imem_addr, 0);
    chk("ar_post_valid", p1_valid, 0); tick();
    set(1, 32'h9999_8888, 1, 0, 0); chk("ar_wait_valid", p1_valid, 0); tick();
    set(0, 0, 1, 0, 0); chk("ar_first_valid", p1_valid, 1); chk("ar_first_pc", p1_pc, 0); tick();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
